// File: rtl/add_pkg.sv
// ---------------------------------------------------------------------------
// add_pkg: shared adder widths, operand/sum types and arbiter state encoding.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package add_pkg;

  localparam int ADD_W = 32;
  localparam int SUM_W = 33;

  typedef logic [ADD_W-1:0] add_op_t;
  typedef logic [SUM_W-1:0] add_sum_t;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/full_add.sv
// ---------------------------------------------------------------------------
// full_add: unsigned ripple-carry adder; carry out lands in the sum MSB.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module full_add
  import add_pkg::*;
(
  input  logic     [ADD_W-1:0] a,
  input  logic     [ADD_W-1:0] b,
  input  logic                 cin,
  output add_sum_t             sum
);

  logic [ADD_W:0]   carry;
  logic [ADD_W-1:0] bit_sum;

  assign carry[0] = cin;

  for (genvar i = 0; i < ADD_W; i++) begin : g_bit
    assign bit_sum[i]  = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1]  = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign sum = {carry[ADD_W], bit_sum};

endmodule

`default_nettype wire

// File: rtl/add_share_arb.sv
// ---------------------------------------------------------------------------
// add_share_arb: round-robin arbiter sharing one full_add among NREQ requesters.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module add_share_arb
  import add_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ADD_W-1:0] req_a,
  input  logic [NREQ*ADD_W-1:0] req_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output add_sum_t              res_sum,
  output logic [IDW-1:0]        res_id,
  output logic                  busy
);

  arb_state_t     state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic [IDW-1:0] win;
  logic           found;
  logic           free;
  logic           accept;
  add_op_t        a_win, b_win;
  add_sum_t       sum_nxt;

  // Rotating priority: first valid requester at or after ptr, wrapping mod NREQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign res_valid = (state == ST_FULL);
  assign free      = ~res_valid | res_ready;
  assign accept    = free & found & rst_n;
  assign ptr_nxt   = IDW'((int'(win) + 1) % NREQ);
  assign busy      = res_valid | (|req_valid);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  assign a_win = req_a[ADD_W*win +: ADD_W];
  assign b_win = req_b[ADD_W*win +: ADD_W];

  full_add u_full_add (
    .a   (a_win),
    .b   (b_win),
    .cin (1'b0),
    .sum (sum_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (!accept && res_ready) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      res_sum <= '0;
      res_id  <= '0;
      ptr     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        res_sum <= sum_nxt;
        res_id  <= win;
        ptr     <= ptr_nxt;
      end
    end
  end

endmodule

`default_nettype wire
